// File: rtl/vec_lsu_pkg.sv
// vec_lsu_pkg: shared encodings and lane helpers for the strided vector LSU.
// SEW encodings, FSM state constants, element extract / replicate / strobe
// generation and the per-SEW alignment check.
package vec_lsu_pkg;

    localparam logic [2:0] SEW_E8  = 3'd0;
    localparam logic [2:0] SEW_E16 = 3'd1;
    localparam logic [2:0] SEW_E32 = 3'd2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RDVRF = 3'd1;
    localparam logic [2:0] ST_MEM   = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    // Pull one element out of a 32-bit word and zero-extend it.
    // An aligned e16 offset is 0 or 2, so a byte-granular shift selects the half.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [2:0]  sew,
                                                 input logic [1:0]  off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (sew)
            SEW_E8:  lane_extract = {24'd0, sh[7:0]};
            SEW_E16: lane_extract = {16'd0, sh[15:0]};
            SEW_E32: lane_extract = word;
            default: lane_extract = 32'd0;
        endcase
    endfunction

    // Copy the element into every lane so the strobes alone pick the bytes.
    function automatic logic [31:0] lane_replicate(input logic [31:0] elem,
                                                   input logic [2:0]  sew);
        case (sew)
            SEW_E8:  lane_replicate = {4{elem[7:0]}};
            SEW_E16: lane_replicate = {2{elem[15:0]}};
            SEW_E32: lane_replicate = elem;
            default: lane_replicate = 32'd0;
        endcase
    endfunction

    // Byte strobes for an element at byte offset off.
    function automatic logic [3:0] gen_wstrb(input logic [2:0] sew,
                                             input logic [1:0] off);
        case (sew)
            SEW_E8:  gen_wstrb = 4'b0001 << off;
            SEW_E16: gen_wstrb = 4'b0011 << {off[1], 1'b0};
            SEW_E32: gen_wstrb = 4'b1111;
            default: gen_wstrb = 4'b0000;
        endcase
    endfunction

    // Natural alignment check for the element size.
    function automatic logic misaligned(input logic [2:0] sew,
                                        input logic [1:0] off);
        case (sew)
            SEW_E16: misaligned = off[0];
            SEW_E32: misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vec_lsu_lane.sv
// vec_lsu_lane: combinational element extract (loads) and lane insert with
// byte strobes (stores) for one 32-bit memory word.
module vec_lsu_lane
    import vec_lsu_pkg::*;
(
    input  logic [2:0]  sew_i,
    input  logic [1:0]  roff_i,
    input  logic [31:0] rword_i,
    output logic [31:0] relem_o,
    input  logic [1:0]  woff_i,
    input  logic [31:0] welem_i,
    output logic [31:0] wword_o,
    output logic [3:0]  wstrb_o
);

    // Load path: select and zero-extend the addressed element.
    always_comb begin
        relem_o = lane_extract(rword_i, sew_i, roff_i);
    end

    // Store path: replicate the element and enable only its byte lanes.
    always_comb begin
        wword_o = lane_replicate(welem_i, sew_i);
        wstrb_o = gen_wstrb(sew_i, woff_i);
    end

endmodule

// File: rtl/vec_strided_lsu.sv
// vec_strided_lsu: strided vector load/store sequencer (vlse.v / vsse.v).
// One 32-bit word access per element; loads write the VRF one element per
// cycle, stores read the VRF then drive replicated data with byte strobes.
// Optional build macro VEC_LSU_COALESCE_EN: loads reuse the last fetched word
// when the next element falls in the same word (tag = addr[31:2]).
module vec_strided_lsu
    import vec_lsu_pkg::*;
#(
    parameter int MAX_VL = 32,
    parameter int IDXW   = $clog2(MAX_VL)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [31:0]     req_base,
    input  logic [31:0]     req_stride,
    input  logic [IDXW:0]   req_vl,
    input  logic [2:0]      req_sew,
    output logic            vrf_we,
    output logic [IDXW-1:0] vrf_widx,
    output logic [31:0]     vrf_wdata,
    output logic            vrf_re,
    output logic [IDXW-1:0] vrf_ridx,
    input  logic [31:0]     vrf_rdata,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic [31:0]     mem_rdata,
    output logic            done,
    output logic            err
);

    logic [2:0]      state_q, state_d;
    logic            rd_phase_q, rd_phase_d;
    logic            store_q, store_d;
    logic [2:0]      sew_q, sew_d;
    logic [31:0]     stride_q, stride_d;
    logic [31:0]     cur_addr_q, cur_addr_d;
    logic [IDXW:0]   vl_q, vl_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic            req_ready_q, mem_valid_q, vrf_we_q, vrf_re_q, done_q, err_q;
    logic [IDXW-1:0] vrf_widx_q, vrf_ridx_q;
    logic [31:0]     vrf_wdata_q, vrf_wdata_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_wstrb_q, mem_wstrb_d;
    logic            fin_err_s;

    logic [31:0]     addr_next_s;
    logic [IDXW:0]   idx_inc_s;
    logic [IDXW:0]   vl_clamp_s;
    logic [31:0]     lane_rword_s, lane_relem_s, lane_wword_s;
    logic [1:0]      lane_roff_s;
    logic [3:0]      lane_wstrb_s;

`ifdef VEC_LSU_COALESCE_EN
    logic [31:0]     cache_q, cache_d;
    logic [29:0]     tag_q, tag_d;
    logic            tag_vld_q, tag_vld_d;
`endif

    assign addr_next_s = cur_addr_q + stride_q;
    assign idx_inc_s   = {1'b0, idx_q} + {{IDXW{1'b0}}, 1'b1};
    assign vl_clamp_s  = (req_vl > (IDXW+1)'(MAX_VL)) ? (IDXW+1)'(MAX_VL) : req_vl;

`ifdef VEC_LSU_COALESCE_EN
    // In WB the extract unit serves the cached word at the next address.
    assign lane_rword_s = (state_q == ST_WB) ? cache_q : mem_rdata;
    assign lane_roff_s  = (state_q == ST_WB) ? addr_next_s[1:0] : cur_addr_q[1:0];
`else
    assign lane_rword_s = mem_rdata;
    assign lane_roff_s  = cur_addr_q[1:0];
`endif

    vec_lsu_lane u_lane (
        .sew_i   (sew_q),
        .roff_i  (lane_roff_s),
        .rword_i (lane_rword_s),
        .relem_o (lane_relem_s),
        .woff_i  (cur_addr_q[1:0]),
        .welem_i (vrf_rdata),
        .wword_o (lane_wword_s),
        .wstrb_o (lane_wstrb_s)
    );

    // Sequencer next state: accept, per-element read/access/writeback, finish.
    always_comb begin
        state_d     = state_q;
        rd_phase_d  = rd_phase_q;
        store_d     = store_q;
        sew_d       = sew_q;
        stride_d    = stride_q;
        cur_addr_d  = cur_addr_q;
        vl_d        = vl_q;
        idx_d       = idx_q;
        vrf_wdata_d = vrf_wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        fin_err_s   = 1'b0;
`ifdef VEC_LSU_COALESCE_EN
        cache_d     = cache_q;
        tag_d       = tag_q;
        tag_vld_d   = tag_vld_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    store_d    = req_store;
                    sew_d      = req_sew;
                    stride_d   = req_stride;
                    vl_d       = vl_clamp_s;
                    cur_addr_d = req_base;
                    idx_d      = {IDXW{1'b0}};
`ifdef VEC_LSU_COALESCE_EN
                    tag_vld_d  = 1'b0;
`endif
                    if ((vl_clamp_s == {(IDXW+1){1'b0}}) || (req_sew > SEW_E32)) begin
                        state_d   = ST_FIN;
                        fin_err_s = (req_sew > SEW_E32);
                    end else if (req_store) begin
                        state_d    = ST_RDVRF;
                        rd_phase_d = 1'b0;
                    end else if (misaligned(req_sew, req_base[1:0])) begin
                        state_d   = ST_FIN;
                        fin_err_s = 1'b1;
                    end else begin
                        state_d     = ST_MEM;
                        mem_addr_d  = {req_base[31:2], 2'b00};
                        mem_wdata_d = 32'd0;
                        mem_wstrb_d = 4'b0000;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RDVRF: begin
                // Phase 0 strobes the VRF read; phase 1 consumes vrf_rdata.
                if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else if (misaligned(sew_q, cur_addr_q[1:0])) begin
                    state_d   = ST_FIN;
                    fin_err_s = 1'b1;
                end else begin
                    state_d     = ST_MEM;
                    mem_addr_d  = {cur_addr_q[31:2], 2'b00};
                    mem_wdata_d = lane_wword_s;
                    mem_wstrb_d = lane_wstrb_s;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d     = ST_WB;
                    vrf_wdata_d = store_q ? 32'd0 : lane_relem_s;
                    mem_addr_d  = 32'd0;
                    mem_wdata_d = 32'd0;
                    mem_wstrb_d = 4'b0000;
`ifdef VEC_LSU_COALESCE_EN
                    cache_d     = mem_rdata;
                    tag_d       = cur_addr_q[31:2];
                    tag_vld_d   = !store_q;
`endif
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                idx_d      = idx_inc_s[IDXW-1:0];
                cur_addr_d = addr_next_s;
                if (idx_inc_s == vl_q) begin
                    state_d = ST_FIN;
                end else if (store_q) begin
                    state_d    = ST_RDVRF;
                    rd_phase_d = 1'b0;
                end else if (misaligned(sew_q, addr_next_s[1:0])) begin
                    state_d   = ST_FIN;
                    fin_err_s = 1'b1;
`ifdef VEC_LSU_COALESCE_EN
                end else if (tag_vld_q && (tag_q == addr_next_s[31:2])) begin
                    state_d     = ST_WB;
                    vrf_wdata_d = lane_relem_s;
`endif
                end else begin
                    state_d     = ST_MEM;
                    mem_addr_d  = {addr_next_s[31:2], 2'b00};
                    mem_wdata_d = 32'd0;
                    mem_wstrb_d = 4'b0000;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, request context and registered outputs (decoded from next state).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            rd_phase_q  <= 1'b0;
            store_q     <= 1'b0;
            sew_q       <= 3'd0;
            stride_q    <= 32'd0;
            cur_addr_q  <= 32'd0;
            vl_q        <= {(IDXW+1){1'b0}};
            idx_q       <= {IDXW{1'b0}};
            req_ready_q <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'b0000;
            vrf_we_q    <= 1'b0;
            vrf_widx_q  <= {IDXW{1'b0}};
            vrf_wdata_q <= 32'd0;
            vrf_re_q    <= 1'b0;
            vrf_ridx_q  <= {IDXW{1'b0}};
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef VEC_LSU_COALESCE_EN
            cache_q     <= 32'd0;
            tag_q       <= 30'd0;
            tag_vld_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rd_phase_q  <= rd_phase_d;
            store_q     <= store_d;
            sew_q       <= sew_d;
            stride_q    <= stride_d;
            cur_addr_q  <= cur_addr_d;
            vl_q        <= vl_d;
            idx_q       <= idx_d;
            req_ready_q <= (state_d == ST_IDLE);
            mem_valid_q <= (state_d == ST_MEM);
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            vrf_we_q    <= (state_d == ST_WB) && !store_d;
            vrf_widx_q  <= (state_d == ST_WB) ? idx_d : {IDXW{1'b0}};
            vrf_wdata_q <= vrf_wdata_d;
            vrf_re_q    <= (state_d == ST_RDVRF) && !rd_phase_d;
            vrf_ridx_q  <= (state_d == ST_RDVRF) ? idx_d : {IDXW{1'b0}};
            done_q      <= (state_d == ST_FIN);
            err_q       <= fin_err_s;
`ifdef VEC_LSU_COALESCE_EN
            cache_q     <= cache_d;
            tag_q       <= tag_d;
            tag_vld_q   <= tag_vld_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign vrf_we    = vrf_we_q;
    assign vrf_widx  = vrf_widx_q;
    assign vrf_wdata = vrf_wdata_q;
    assign vrf_re    = vrf_re_q;
    assign vrf_ridx  = vrf_ridx_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_vec_strided_lsu.sv
// tb_vec_strided_lsu: directed bench for vec_strided_lsu with a word memory
// model, a VRF read model and logs of memory accesses and VRF writes.
module tb_vec_strided_lsu;

    localparam int IDXW = 5;

    logic            clk;
    logic            resetn;
    logic            req_valid, req_ready, req_store;
    logic [31:0]     req_base, req_stride;
    logic [IDXW:0]   req_vl;
    logic [2:0]      req_sew;
    logic            vrf_we, vrf_re;
    logic [IDXW-1:0] vrf_widx, vrf_ridx;
    logic [31:0]     vrf_wdata, vrf_rdata;
    logic            mem_valid, mem_ready;
    logic [31:0]     mem_addr, mem_wdata, mem_rdata;
    logic [3:0]      mem_wstrb;
    logic            done, err;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int errdone_cnt = 0;
    bit hold_ready = 1'b0;

    logic [31:0]     mem [0:255];
    logic [31:0]     vrf_mem [0:31];
    logic [31:0]     acc_addr[$];
    logic [31:0]     acc_wdata[$];
    logic [3:0]      acc_strb[$];
    logic [IDXW-1:0] wr_idx[$];
    logic [31:0]     wr_data[$];

    vec_strided_lsu #(.MAX_VL(32)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_base(req_base), .req_stride(req_stride), .req_vl(req_vl), .req_sew(req_sew),
        .vrf_we(vrf_we), .vrf_widx(vrf_widx), .vrf_wdata(vrf_wdata),
        .vrf_re(vrf_re), .vrf_ridx(vrf_ridx), .vrf_rdata(vrf_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .done(done), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory / VRF responder and output logger, active on the falling edge.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        vrf_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (resetn !== 1'b1) begin
                mem_ready = 1'b0;
            end else begin
                if (vrf_we) begin
                    wr_idx.push_back(vrf_widx);
                    wr_data.push_back(vrf_wdata);
                end
                if (done) begin
                    done_cnt++;
                    if (err) errdone_cnt++;
                end
                if (err) err_cnt++;
                if (vrf_re) vrf_rdata = vrf_mem[vrf_ridx];
                if (mem_valid && !mem_ready && !hold_ready) begin
                    acc_addr.push_back(mem_addr);
                    acc_strb.push_back(mem_wstrb);
                    acc_wdata.push_back(mem_wdata);
                    mem_rdata = mem[mem_addr[9:2]];
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    mem_ready = 1'b1;
                end else begin
                    mem_ready = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic st, input logic [31:0] base, input logic [31:0] stride,
                         input logic [IDXW:0] vl, input logic [2:0] sew);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_base   = base;
        req_stride = stride;
        req_vl     = vl;
        req_sew    = sew;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int start);
        int n;
        n = 0;
        while (done_cnt == start && n < 1000) begin
            @(posedge clk);
            n++;
        end
        n_checks++;
        if (done_cnt == start) begin
            n_fail++;
            $display("FAIL %s_timeout: got no done within %0d cycles, required a done pulse", name, n);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        req_valid = 1'b0; req_store = 1'b0; req_base = 32'd0;
        req_stride = 32'd0; req_vl = '0; req_sew = 3'd0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
        n_checks++;
        if ({mem_valid, vrf_we, vrf_re, done, err} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_strobes: got %b required 00000", {mem_valid, vrf_we, vrf_re, done, err});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== 68'd0) begin
            n_fail++; $display("FAIL reset_mem_bus: got %h required 0", {mem_addr, mem_wdata, mem_wstrb});
        end
    endtask

    task automatic test_load_e16;
        logic [31:0] exp_d [4] = '{32'h0201, 32'h0a09, 32'h1211, 32'h1a19};
        logic [31:0] exp_a [4] = '{32'd400, 32'd408, 32'd416, 32'd424};
        int a0, w0, d0, e0;
        a0 = acc_addr.size(); w0 = wr_data.size(); d0 = done_cnt; e0 = err_cnt;
        issue(1'b0, 32'd400, 32'd8, 6'd4, 3'd1);
        wait_done("load_e16", d0);
        n_checks++;
        if (wr_data.size() - w0 != 4) begin n_fail++; $display("FAIL load_e16_nwr: got %0d required 4", wr_data.size() - w0); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wr_data.size() <= w0 + i || wr_data[w0+i] !== exp_d[i] || wr_idx[w0+i] !== i[IDXW-1:0]) begin
                n_fail++; $display("FAIL load_e16_wr%0d: got idx %0d data %h required idx %0d data %h",
                                   i, wr_idx[w0+i], wr_data[w0+i], i, exp_d[i]);
            end
            n_checks++;
            if (acc_addr.size() <= a0 + i || acc_addr[a0+i] !== exp_a[i] || acc_strb[a0+i] !== 4'b0000) begin
                n_fail++; $display("FAIL load_e16_acc%0d: got addr %0d strb %b required addr %0d strb 0000",
                                   i, acc_addr[a0+i], acc_strb[a0+i], exp_a[i]);
            end
        end
        n_checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            n_fail++; $display("FAIL load_e16_done: got done %0d err %0d required done 1 err 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_store_e8;
        logic [3:0] exp_s [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        int a0, d0;
        a0 = acc_addr.size(); d0 = done_cnt;
        issue(1'b1, 32'd600, 32'd1, 6'd4, 3'd0);
        // A request while busy must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_base = 32'd0; req_vl = 6'd2;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL store_busy_ready: got %b required 0", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        wait_done("store_e8", d0);
        n_checks++;
        if (acc_addr.size() - a0 != 4) begin n_fail++; $display("FAIL store_e8_nacc: got %0d required 4", acc_addr.size() - a0); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (acc_addr.size() <= a0 + i || acc_addr[a0+i] !== 32'd600 || acc_strb[a0+i] !== exp_s[i]) begin
                n_fail++; $display("FAIL store_e8_acc%0d: got addr %0d strb %b required addr 600 strb %b",
                                   i, acc_addr[a0+i], acc_strb[a0+i], exp_s[i]);
            end
        end
        n_checks++;
        if (acc_wdata.size() <= a0 || acc_wdata[a0] !== 32'hAAAAAAAA) begin
            n_fail++; $display("FAIL store_e8_wdata0: got %h required aaaaaaaa", acc_wdata[a0]);
        end
        n_checks++;
        if (mem[150] !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL store_e8_mem: got %h required ddccbbaa", mem[150]); end
        n_checks++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL store_e8_done: got %0d required 1", done_cnt - d0); end
    endtask

    task automatic test_load_e32_neg;
        logic [31:0] exp_d [3] = '{32'hDEAD0110, 32'h5A5A0109, 32'hA5A50108};
        logic [31:0] exp_a [3] = '{32'd440, 32'd436, 32'd432};
        int a0, w0, d0;
        a0 = acc_addr.size(); w0 = wr_data.size(); d0 = done_cnt;
        issue(1'b0, 32'd440, 32'hFFFFFFFC, 6'd3, 3'd2);
        wait_done("load_e32", d0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (acc_addr.size() <= a0 + i || acc_addr[a0+i] !== exp_a[i]) begin
                n_fail++; $display("FAIL load_e32_addr%0d: got %0d required %0d", i, acc_addr[a0+i], exp_a[i]);
            end
            n_checks++;
            if (wr_data.size() <= w0 + i || wr_data[w0+i] !== exp_d[i]) begin
                n_fail++; $display("FAIL load_e32_data%0d: got %h required %h", i, wr_data[w0+i], exp_d[i]);
            end
        end
    endtask

    task automatic test_misaligned;
        int a0, w0, d0, e0, x0;
        a0 = acc_addr.size(); w0 = wr_data.size(); d0 = done_cnt; e0 = err_cnt; x0 = errdone_cnt;
        issue(1'b0, 32'd401, 32'd2, 6'd2, 3'd1);
        wait_done("misalign_start", d0);
        n_checks++;
        if (acc_addr.size() != a0 || wr_data.size() != w0) begin
            n_fail++; $display("FAIL misalign_start_traffic: got acc %0d wr %0d required 0 0", acc_addr.size() - a0, wr_data.size() - w0);
        end
        n_checks++;
        if (errdone_cnt - x0 != 1 || err_cnt - e0 != 1) begin
            n_fail++; $display("FAIL misalign_start_err: got err+done %0d err %0d required 1 1", errdone_cnt - x0, err_cnt - e0);
        end
        // Second element at 402 breaks e32 alignment after one good element.
        a0 = acc_addr.size(); w0 = wr_data.size(); d0 = done_cnt; x0 = errdone_cnt;
        issue(1'b0, 32'd400, 32'd2, 6'd3, 3'd2);
        wait_done("misalign_mid", d0);
        n_checks++;
        if (acc_addr.size() - a0 != 1 || wr_data.size() - w0 != 1 || errdone_cnt - x0 != 1) begin
            n_fail++; $display("FAIL misalign_mid_counts: got acc %0d wr %0d errdone %0d required 1 1 1",
                               acc_addr.size() - a0, wr_data.size() - w0, errdone_cnt - x0);
        end
        n_checks++;
        if (wr_data.size() <= w0 || wr_data[w0] !== 32'h04030201) begin
            n_fail++; $display("FAIL misalign_mid_data: got %h required 04030201", wr_data[w0]);
        end
    endtask

    task automatic test_empty_and_illegal;
        int a0;
        a0 = acc_addr.size();
        issue(1'b0, 32'd400, 32'd4, 6'd0, 3'd2);
        @(negedge clk);
        n_checks++;
        if ({done, err, req_ready} !== 3'b100) begin
            n_fail++; $display("FAIL vl0_done: got done/err/ready %b required 100", {done, err, req_ready});
        end
        issue(1'b1, 32'd400, 32'd4, 6'd3, 3'd3);
        @(negedge clk);
        n_checks++;
        if ({done, err} !== 2'b11) begin n_fail++; $display("FAIL sew3_done: got done/err %b required 11", {done, err}); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (acc_addr.size() != a0) begin n_fail++; $display("FAIL empty_traffic: got %0d accesses required 0", acc_addr.size() - a0); end
    endtask

    task automatic test_clamp_stride0;
        int a0, w0, d0, exp_acc;
        a0 = acc_addr.size(); w0 = wr_data.size(); d0 = done_cnt;
`ifdef VEC_LSU_COALESCE_EN
        exp_acc = 1;
`else
        exp_acc = 32;
`endif
        issue(1'b0, 32'd400, 32'd0, 6'd40, 3'd0);
        wait_done("clamp", d0);
        n_checks++;
        if (wr_data.size() - w0 != 32) begin n_fail++; $display("FAIL clamp_nwr: got %0d required 32", wr_data.size() - w0); end
        n_checks++;
        if (wr_idx.size() != w0 + 32 || wr_idx[w0+31] !== 5'd31 || wr_data[w0+31] !== 32'h01) begin
            n_fail++; $display("FAIL clamp_last: got idx %0d data %h required 31 01", wr_idx[wr_idx.size()-1], wr_data[wr_data.size()-1]);
        end
        n_checks++;
        if (acc_addr.size() - a0 != exp_acc) begin
            n_fail++; $display("FAIL stride0_nacc: got %0d required %0d", acc_addr.size() - a0, exp_acc);
        end
    endtask

    task automatic test_reset_mid_op;
        int d0, n;
        d0 = done_cnt;
        hold_ready = 1'b1;
        issue(1'b0, 32'd400, 32'd4, 6'd4, 3'd2);
        n = 0;
        while (mem_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_checks++;
        if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_valid: got %b required 1", mem_valid); end
        #1;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_abort: got mem_valid %b required 0", mem_valid); end
        @(negedge clk);
        hold_ready = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_release: got ready %b valid %b required 1 0", req_ready, mem_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt != d0) begin n_fail++; $display("FAIL rst_mid_nodone: got %0d done pulses required 0", done_cnt - d0); end
    endtask

`ifdef VEC_LSU_COALESCE_EN
    task automatic test_coalesce;
        int a0, w0, d0;
        a0 = acc_addr.size(); w0 = wr_data.size(); d0 = done_cnt;
        issue(1'b0, 32'd400, 32'd1, 6'd8, 3'd0);
        wait_done("coalesce", d0);
        n_checks++;
        if (acc_addr.size() - a0 != 2 || acc_addr[a0] !== 32'd400 || acc_addr[a0+1] !== 32'd404) begin
            n_fail++; $display("FAIL coalesce_acc: got %0d accesses required 2 at 400,404", acc_addr.size() - a0);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (wr_data.size() <= w0 + i || wr_data[w0+i] !== 32'(i + 1)) begin
                n_fail++; $display("FAIL coalesce_data%0d: got %h required %h", i, wr_data[w0+i], i + 1);
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[100] = 32'h04030201; mem[101] = 32'h08070605;
        mem[102] = 32'h0c0b0a09; mem[103] = 32'h000f0e0d;
        mem[104] = 32'h14131211; mem[105] = 32'h18171615;
        mem[106] = 32'h1c1b1a19; mem[107] = 32'h101f1e1d;
        mem[108] = 32'hA5A50108; mem[109] = 32'h5A5A0109; mem[110] = 32'hDEAD0110;
        for (int i = 0; i < 32; i++) vrf_mem[i] = 32'd0;
        vrf_mem[0] = 32'hAA; vrf_mem[1] = 32'hBB; vrf_mem[2] = 32'hCC; vrf_mem[3] = 32'hDD;

        test_reset;
        test_load_e16;
        test_store_e8;
        test_load_e32_neg;
        test_misaligned;
        test_empty_and_illegal;
        test_clamp_stride0;
`ifdef VEC_LSU_COALESCE_EN
        test_coalesce;
`endif
        test_reset_mid_op;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
